// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter: FSM state encoding and
// the MEM_Control access-size codes used by the MEM stage.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_BUS_IF    = 2'd1,
    ARB_BUS_DATA  = 2'd2,
    ARB_FAULT_RSP = 2'd3
  } arb_state_t;

  // 011, 110 and 111 are unused codes and are reported as illegal.
  localparam logic [2:0] MEM_BYTE              = 3'b000;
  localparam logic [2:0] MEM_HALFWORD          = 3'b001;
  localparam logic [2:0] MEM_WORD              = 3'b010;
  localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'b100;
  localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'b101;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data port. The store side produces the lane
// enables, the lane-replicated write data and the illegal-access flag. The load
// side shifts the addressed lane down and sign/zero-extends it.
module mem_lane_align
  import unified_mem_arbiter_pkg::*;
(
  input  logic [2:0]  st_ctrl_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o,
  output logic        illegal_o,
  input  logic [2:0]  ld_ctrl_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] rd_shift;

  // Store-side lane enables, replicated data and alignment check.
  always_comb begin
    byte_en_o = 4'b0000;
    wdata_o   = 32'h0;
    illegal_o = 1'b0;
    case (st_ctrl_i)
      MEM_BYTE, MEM_BYTE_UNSIGNED: begin
        byte_en_o = 4'b0001 << st_off_i;
        wdata_o   = {4{st_wdata_i[7:0]}};
      end
      MEM_HALFWORD, MEM_HALFWORD_UNSIGNED: begin
        byte_en_o = 4'b0011 << st_off_i;
        wdata_o   = {2{st_wdata_i[15:0]}};
        illegal_o = st_off_i[0];
      end
      MEM_WORD: begin
        byte_en_o = 4'b1111;
        wdata_o   = st_wdata_i;
        illegal_o = (st_off_i != 2'b00);
      end
      default: illegal_o = 1'b1;
    endcase
  end

  // Load-side lane extraction followed by sign or zero extension.
  always_comb begin
    rd_shift  = rdata_i >> {ld_off_i, 3'b000};
    ld_data_o = 32'h0;
    case (ld_ctrl_i)
      MEM_BYTE:              ld_data_o = {{24{rd_shift[7]}}, rd_shift[7:0]};
      MEM_BYTE_UNSIGNED:     ld_data_o = {24'h0, rd_shift[7:0]};
      MEM_HALFWORD:          ld_data_o = {{16{rd_shift[15]}}, rd_shift[15:0]};
      MEM_HALFWORD_UNSIGNED: ld_data_o = {16'h0, rd_shift[15:0]};
      MEM_WORD:              ld_data_o = rd_shift;
      default:               ld_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory bus between the fetch port and the load/store
// port: arbitration with starvation guard, req/ack sequencing, bus timeout.
//
//   state          | meaning
//   ---------------+---------------------------------------------------------
//   ARB_IDLE       | no bus cycle open; pick a port or report an illegal access
//   ARB_BUS_IF     | fetch cycle on the bus, waiting for Bus_Ack or timeout
//   ARB_BUS_DATA   | load/store cycle on the bus, waiting for Bus_Ack or timeout
//   ARB_FAULT_RSP  | illegal data access; MEM_Ready+MEM_Fault shown this cycle
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IF_Req,
  input  logic [31:0] IF_Addr,
  output logic [31:0] IF_Instr,
  output logic        IF_Ready,
  output logic        IF_Fault,
  input  logic        MEM_Req,
  input  logic        MEM_Write_En,
  input  logic [2:0]  MEM_Control,
  input  logic [31:0] MEM_Addr,
  input  logic [31:0] MEM_WData,
  output logic [31:0] MEM_RData,
  output logic        MEM_Ready,
  output logic        MEM_Fault,
  output logic        Bus_Req,
  output logic        Bus_We,
  output logic [3:0]  Bus_Byte_En,
  output logic [31:0] Bus_Addr,
  output logic [31:0] Bus_WData,
  input  logic [31:0] Bus_RData,
  input  logic        Bus_Ack
);

  localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LOAD_C   = 8'(TIMEOUT_CYCLES - 1);

  arb_state_t  state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        if_ready_q, if_ready_d, if_fault_q, if_fault_d;
  logic [31:0] if_instr_q, if_instr_d, mem_rdata_q, mem_rdata_d;
  logic        mem_ready_q, mem_ready_d, mem_fault_q, mem_fault_d;

  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;
  logic        st_illegal;
  logic        unused_if_addr;

  assign unused_if_addr = ^IF_Addr[1:0];

  mem_lane_align u_align (
    .st_ctrl_i  (MEM_Control),
    .st_off_i   (MEM_Addr[1:0]),
    .st_wdata_i (MEM_WData),
    .byte_en_o  (st_be),
    .wdata_o    (st_wdata),
    .illegal_o  (st_illegal),
    .ld_ctrl_i  (ctrl_q),
    .ld_off_i   (off_q),
    .rdata_i    (Bus_RData),
    .ld_data_o  (ld_data)
  );

  // Arbitration, bus sequencing and completion/fault responses.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_be_d    = bus_be_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    off_d       = off_q;
    ctrl_d      = ctrl_q;
    if_ready_d  = 1'b0;
    if_fault_d  = 1'b0;
    if_instr_d  = 32'h0;
    mem_ready_d = 1'b0;
    mem_fault_d = 1'b0;
    mem_rdata_d = 32'h0;
    case (state_q)
      ARB_IDLE: begin
        if (MEM_Req && (!IF_Req || (starve_q < STARVE_LIM_C))) begin
          if (IF_Req) starve_d = starve_q + 4'd1;
          if (st_illegal) begin
            state_d     = ARB_FAULT_RSP;
            mem_ready_d = 1'b1;
            mem_fault_d = 1'b1;
          end else begin
            state_d     = ARB_BUS_DATA;
            bus_req_d   = 1'b1;
            bus_we_d    = MEM_Write_En;
            bus_be_d    = st_be;
            bus_addr_d  = {MEM_Addr[31:2], 2'b00};
            bus_wdata_d = MEM_Write_En ? st_wdata : 32'h0;
            off_d       = MEM_Addr[1:0];
            ctrl_d      = MEM_Control;
            tmo_d       = TMO_LOAD_C;
          end
        end else if (IF_Req) begin
          state_d     = ARB_BUS_IF;
          starve_d    = 4'd0;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_be_d    = 4'b1111;
          bus_addr_d  = {IF_Addr[31:2], 2'b00};
          bus_wdata_d = 32'h0;
          tmo_d       = TMO_LOAD_C;
        end
      end
      ARB_BUS_IF, ARB_BUS_DATA: begin
        if (Bus_Ack) begin
          state_d   = ARB_IDLE;
          bus_req_d = 1'b0;
          if (state_q == ARB_BUS_IF) begin
            // A fetch flushed while on the bus still completes, silently.
            if_ready_d = IF_Req;
            if_instr_d = IF_Req ? Bus_RData : 32'h0;
          end else begin
            mem_ready_d = 1'b1;
            mem_rdata_d = bus_we_q ? 32'h0 : ld_data;
          end
        end else if (tmo_q == 8'd0) begin
          state_d   = ARB_IDLE;
          bus_req_d = 1'b0;
          if (state_q == ARB_BUS_IF) begin
            if_ready_d = 1'b1;
            if_fault_d = 1'b1;
          end else begin
            mem_ready_d = 1'b1;
            mem_fault_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= ARB_IDLE;
      starve_q    <= 4'd0;
      tmo_q       <= 8'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= 4'b0000;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      off_q       <= 2'b00;
      ctrl_q      <= 3'b000;
      if_ready_q  <= 1'b0;
      if_fault_q  <= 1'b0;
      if_instr_q  <= 32'h0;
      mem_ready_q <= 1'b0;
      mem_fault_q <= 1'b0;
      mem_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      off_q       <= off_d;
      ctrl_q      <= ctrl_d;
      if_ready_q  <= if_ready_d;
      if_fault_q  <= if_fault_d;
      if_instr_q  <= if_instr_d;
      mem_ready_q <= mem_ready_d;
      mem_fault_q <= mem_fault_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign IF_Instr    = if_instr_q;
  assign IF_Ready    = if_ready_q;
  assign IF_Fault    = if_fault_q;
  assign MEM_RData   = mem_rdata_q;
  assign MEM_Ready   = mem_ready_q;
  assign MEM_Fault   = mem_fault_q;
  assign Bus_Req     = bus_req_q;
  assign Bus_We      = bus_we_q;
  assign Bus_Byte_En = bus_be_q;
  assign Bus_Addr    = bus_addr_q;
  assign Bus_WData   = bus_wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: fetch, load extension, store lanes,
// illegal access, timeout, reset abort, flush and starvation ordering.
module tb_unified_mem_arbiter;
  import unified_mem_arbiter_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        IF_Req = 1'b0;
  logic [31:0] IF_Addr = 32'h0;
  logic [31:0] IF_Instr;
  logic        IF_Ready, IF_Fault;
  logic        MEM_Req = 1'b0;
  logic        MEM_Write_En = 1'b0;
  logic [2:0]  MEM_Control = 3'b000;
  logic [31:0] MEM_Addr = 32'h0;
  logic [31:0] MEM_WData = 32'h0;
  logic [31:0] MEM_RData;
  logic        MEM_Ready, MEM_Fault;
  logic        Bus_Req, Bus_We;
  logic [3:0]  Bus_Byte_En;
  logic [31:0] Bus_Addr, Bus_WData;
  logic [31:0] Bus_RData = 32'h0;
  logic        Bus_Ack;

  // bus responder: ack after wait_n extra cycles of Bus_Req
  logic ack_en = 1'b1;
  int   wait_n = 0;
  int   req_cyc = 0;
  assign Bus_Ack = ack_en && Bus_Req && (req_cyc == wait_n);

  always @(posedge CLK) begin
    if (Bus_Req && !Bus_Ack) req_cyc <= req_cyc + 1;
    else                     req_cyc <= 0;
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  unified_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RST(RST),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Instr(IF_Instr),
    .IF_Ready(IF_Ready), .IF_Fault(IF_Fault),
    .MEM_Req(MEM_Req), .MEM_Write_En(MEM_Write_En), .MEM_Control(MEM_Control),
    .MEM_Addr(MEM_Addr), .MEM_WData(MEM_WData), .MEM_RData(MEM_RData),
    .MEM_Ready(MEM_Ready), .MEM_Fault(MEM_Fault),
    .Bus_Req(Bus_Req), .Bus_We(Bus_We), .Bus_Byte_En(Bus_Byte_En),
    .Bus_Addr(Bus_Addr), .Bus_WData(Bus_WData), .Bus_RData(Bus_RData),
    .Bus_Ack(Bus_Ack)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_mem(input logic we, input logic [2:0] ctrl,
                           input logic [31:0] addr, input logic [31:0] wdata);
    MEM_Req      = 1'b1;
    MEM_Write_En = we;
    MEM_Control  = ctrl;
    MEM_Addr     = addr;
    MEM_WData    = wdata;
  endtask

  task automatic wait_ready(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (IF_Ready || MEM_Ready) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_rdy_seen"}, {31'h0, seen}, 32'h1);
  endtask

  initial begin
    int n;
    logic saw_if;
    logic [7:0] exp_g;

    // reset state
    tick(); tick();
    check("rst_bus_req", {31'h0, Bus_Req}, 32'h0);
    check("rst_bus_en", {28'h0, Bus_Byte_En}, 32'h0);
    check("rst_if_rdy", {31'h0, IF_Ready}, 32'h0);
    check("rst_mem_rdy", {31'h0, MEM_Ready}, 32'h0);
    RST = 1'b1;

    // zero-wait fetch
    wait_n = 0;
    IF_Req = 1'b1; IF_Addr = 32'h0000_0100; Bus_RData = 32'h0050_0093;
    tick();
    check("fetch_bus_req", {31'h0, Bus_Req}, 32'h1);
    check("fetch_bus_addr", Bus_Addr, 32'h0000_0100);
    check("fetch_bus_en", {28'h0, Bus_Byte_En}, 32'hF);
    check("fetch_bus_we", {31'h0, Bus_We}, 32'h0);
    check("fetch_rdy_early", {31'h0, IF_Ready}, 32'h0);
    tick();
    check("fetch_rdy", {31'h0, IF_Ready}, 32'h1);
    check("fetch_instr", IF_Instr, 32'h0050_0093);
    check("fetch_bus_drop", {31'h0, Bus_Req}, 32'h0);
    IF_Req = 1'b0;
    tick();
    check("fetch_rdy_pulse", {31'h0, IF_Ready}, 32'h0);

    // LB at 0x203
    Bus_RData = 32'h80FF_FFFF;
    drive_mem(1'b0, MEM_BYTE, 32'h0000_0203, 32'h0);
    tick();
    check("lb_bus_en", {28'h0, Bus_Byte_En}, 32'h8);
    check("lb_bus_addr", Bus_Addr, 32'h0000_0200);
    wait_ready("lb");
    check("lb_mem_rdy", {31'h0, MEM_Ready}, 32'h1);
    check("lb_rdata", MEM_RData, 32'hFFFF_FF80);
    check("lb_fault", {31'h0, MEM_Fault}, 32'h0);
    MEM_Req = 1'b0;
    tick();

    // LBU at 0x203
    drive_mem(1'b0, MEM_BYTE_UNSIGNED, 32'h0000_0203, 32'h0);
    wait_ready("lbu");
    check("lbu_rdata", MEM_RData, 32'h0000_0080);
    MEM_Req = 1'b0;
    tick();

    // LH at 0x202 -> upper half 0x80FF sign-extended
    drive_mem(1'b0, MEM_HALFWORD, 32'h0000_0202, 32'h0);
    wait_ready("lh");
    check("lh_rdata", MEM_RData, 32'hFFFF_80FF);
    MEM_Req = 1'b0;
    tick();

    // SH 0x1234 at 0x402
    drive_mem(1'b1, MEM_HALFWORD, 32'h0000_0402, 32'h0000_1234);
    tick();
    check("sh_bus_we", {31'h0, Bus_We}, 32'h1);
    check("sh_bus_en", {28'h0, Bus_Byte_En}, 32'hC);
    check("sh_bus_wdata", Bus_WData, 32'h1234_1234);
    check("sh_bus_addr", Bus_Addr, 32'h0000_0400);
    wait_ready("sh");
    check("sh_rdata", MEM_RData, 32'h0);
    MEM_Req = 1'b0;
    tick();

    // SB 0xA5 at 0x401
    drive_mem(1'b1, MEM_BYTE, 32'h0000_0401, 32'h0000_00A5);
    tick();
    check("sb_bus_en", {28'h0, Bus_Byte_En}, 32'h2);
    check("sb_bus_wdata", Bus_WData, 32'hA5A5_A5A5);
    wait_ready("sb");
    MEM_Req = 1'b0;
    tick();

    // LW misaligned at 0x402
    drive_mem(1'b0, MEM_WORD, 32'h0000_0402, 32'h0);
    tick();
    check("lw_mis_rdy", {31'h0, MEM_Ready}, 32'h1);
    check("lw_mis_fault", {31'h0, MEM_Fault}, 32'h1);
    check("lw_mis_bus_req", {31'h0, Bus_Req}, 32'h0);
    check("lw_mis_rdata", MEM_RData, 32'h0);
    MEM_Req = 1'b0;
    tick();
    check("lw_mis_pulse", {31'h0, MEM_Ready}, 32'h0);

    // illegal control code 011
    drive_mem(1'b0, 3'b011, 32'h0000_0400, 32'h0);
    tick();
    check("ill_fault", {31'h0, MEM_Fault}, 32'h1);
    check("ill_bus_req", {31'h0, Bus_Req}, 32'h0);
    MEM_Req = 1'b0;
    tick();

    // timeout: no ack, Bus_Req high for exactly 8 cycles
    ack_en = 1'b0;
    drive_mem(1'b0, MEM_WORD, 32'h0000_0300, 32'h0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Bus_Req) n++;
      else break;
    end
    check("tmo_cycles", n, 32'd8);
    check("tmo_rdy", {31'h0, MEM_Ready}, 32'h1);
    check("tmo_fault", {31'h0, MEM_Fault}, 32'h1);
    check("tmo_rdata", MEM_RData, 32'h0);
    MEM_Req = 1'b0; ack_en = 1'b1;
    tick();
    Bus_RData = 32'hDEAD_BEEF;
    drive_mem(1'b0, MEM_WORD, 32'h0000_0300, 32'h0);
    wait_ready("post_tmo");
    check("post_tmo_rdata", MEM_RData, 32'hDEAD_BEEF);
    check("post_tmo_fault", {31'h0, MEM_Fault}, 32'h0);
    MEM_Req = 1'b0;
    tick();

    // reset mid BUS_DATA
    ack_en = 1'b0;
    drive_mem(1'b0, MEM_WORD, 32'h0000_0300, 32'h0);
    tick(); tick();
    check("rmid_bus_req_pre", {31'h0, Bus_Req}, 32'h1);
    RST = 1'b0;
    tick();
    check("rmid_bus_req", {31'h0, Bus_Req}, 32'h0);
    check("rmid_bus_addr", Bus_Addr, 32'h0);
    check("rmid_bus_en", {28'h0, Bus_Byte_En}, 32'h0);
    check("rmid_mem_rdy", {31'h0, MEM_Ready}, 32'h0);
    RST = 1'b1; MEM_Req = 1'b0; ack_en = 1'b1;
    tick();
    check("rmid_no_rdy", {31'h0, MEM_Ready}, 32'h0);

    // flush during 3-wait fetch with a pending load
    wait_n = 3;
    Bus_RData = 32'h1122_3344;
    IF_Req = 1'b1; IF_Addr = 32'h0000_0500;
    tick();
    check("fl_bus_addr", Bus_Addr, 32'h0000_0500);
    tick();
    IF_Req = 1'b0;
    drive_mem(1'b0, MEM_WORD, 32'h0000_0600, 32'h0);
    saw_if = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (IF_Ready) saw_if = 1'b1;
      if (!Bus_Req) break;
      n++;
    end
    check("fl_bus_cycles", n, 32'd2);
    check("fl_no_if_rdy", {31'h0, saw_if}, 32'h0);
    tick();
    check("fl_mem_grant", {31'h0, Bus_Req}, 32'h1);
    check("fl_mem_addr", Bus_Addr, 32'h0000_0600);
    wait_ready("fl_mem");
    check("fl_mem_rdy", {31'h0, MEM_Ready}, 32'h1);
    check("fl_mem_rdata", MEM_RData, 32'h1122_3344);
    MEM_Req = 1'b0;
    tick();

    // starvation ordering from a fresh reset
    wait_n = 0;
    RST = 1'b0;
    tick();
    RST = 1'b1;
    IF_Req = 1'b1; IF_Addr = 32'h0000_0700;
    drive_mem(1'b0, MEM_WORD, 32'h0000_0800, 32'h0);
    for (int k = 0; k < 10; k++) begin
      exp_g = (k == 4 || k == 9) ? 8'h49 : 8'h44;
      wait_ready("starve");
      check("starve_excl", {31'h0, IF_Ready & MEM_Ready}, 32'h0);
      check($sformatf("starve_grant%0d", k), {24'h0, (MEM_Ready ? 8'h44 : 8'h49)}, {24'h0, exp_g});
    end
    IF_Req = 1'b0; MEM_Req = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
